// File: rtl/laser_link_pkg.sv
// Shared laser-link definitions: word framing constants, framer states and
// the busy/retry status decode used by both the framer and the control sequencer.
package laser_link_pkg;

  localparam int unsigned LASER_WORD_BYTES  = 4;
  localparam int unsigned UART_CLKS_PER_BIT = 186;

  typedef enum logic [0:0] {
    FRAMER_IDLE    = 1'b0,
    FRAMER_COLLECT = 1'b1
  } framer_state_t;

  function automatic logic is_busy_word(input logic [31:0] word);
    return (word[23:16] == 8'h00) && (word[3:0] != 4'h0);
  endfunction

endpackage

// File: rtl/laser_word_fifo.sv
// First-word-fall-through synchronous FIFO for 32-bit laser response words.
// Reports a dropped push when full and not simultaneously popped.
module laser_word_fifo #(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               pll_rst,
  input  logic               flush,
  input  logic               push,
  input  logic [31:0]        push_data,
  input  logic               pop_req,
  output logic [31:0]        head_data,
  output logic               not_empty,
  output logic [FIFO_AW:0]   level,
  output logic               dropped
);

  localparam int unsigned          DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]     LEVEL_MAX = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]     LEVEL_ONE = 1;
  localparam logic [FIFO_AW-1:0]   PTR_ONE   = 1;

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               empty;
  logic               full;
  logic               do_push;
  logic               do_pop;

  always_comb begin
    empty   = (level == '0);
    full    = (level == LEVEL_MAX);
    do_pop  = pop_req && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push = push && (!full || do_pop);
    dropped = push && full && !do_pop;
  end

  always_ff @(posedge clk or posedge pll_rst) begin
    if (pll_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign not_empty = !empty;
  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/laser_rx_word_framer.sv
// Frames UART receiver bytes into big-endian 32-bit words with an inter-byte
// timeout, buffers them in a FWFT FIFO and flags busy/retry head words.
module laser_rx_word_framer
  import laser_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 25,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic               clk,
  input  logic               pll_rst,
  input  logic               rx_dv,
  input  logic [7:0]         rx_byte,
  input  logic               flush,
  input  logic               rd_en,
  output logic [31:0]        word_out,
  output logic               word_valid,
  output logic               word_busy,
  output logic               byte_timeout,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam logic [1:0]           LAST_BYTE = 2'(LASER_WORD_BYTES - 1);
  localparam logic [1:0]           CNT_ONE   = 2'd1;
  localparam logic [TIMEOUT_W-1:0] TMO_ONE   = 1;

  framer_state_t          state;
  logic [23:0]            shreg;
  logic [1:0]             count;
  logic [TIMEOUT_W-1:0]   tmo_cnt;
  logic [TIMEOUT_W-1:0]   tmo_next;
  logic                   timeout_hit;
  logic                   word_push;
  logic [31:0]            push_word;
  logic                   fifo_dropped;

  always_comb begin
    tmo_next    = tmo_cnt + TMO_ONE;
    // Fire on the edge the counter MSB would set; a coincident byte wins.
    timeout_hit = (state == FRAMER_COLLECT) && !rx_dv && tmo_next[TIMEOUT_W-1];
    word_push   = (state == FRAMER_COLLECT) && rx_dv && (count == LAST_BYTE) && !flush;
    push_word   = {shreg, rx_byte};
  end

  always_ff @(posedge clk or posedge pll_rst) begin
    if (pll_rst) begin
      state        <= FRAMER_IDLE;
      shreg        <= '0;
      count        <= '0;
      tmo_cnt      <= '0;
      byte_timeout <= 1'b0;
      overflow     <= 1'b0;
    end else if (flush) begin
      state        <= FRAMER_IDLE;
      shreg        <= '0;
      count        <= '0;
      tmo_cnt      <= '0;
      byte_timeout <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      byte_timeout <= 1'b0;
      overflow     <= overflow | fifo_dropped;
      case (state)
        FRAMER_IDLE: begin
          tmo_cnt <= '0;
          if (rx_dv) begin
            shreg <= {16'h0000, rx_byte};
            count <= CNT_ONE;
            state <= FRAMER_COLLECT;
          end
        end
        FRAMER_COLLECT: begin
          if (rx_dv) begin
            tmo_cnt <= '0;
            shreg   <= {shreg[15:0], rx_byte};
            if (count == LAST_BYTE) begin
              count <= '0;
              state <= FRAMER_IDLE;
            end else begin
              count <= count + CNT_ONE;
            end
          end else if (timeout_hit) begin
            tmo_cnt      <= '0;
            count        <= '0;
            byte_timeout <= 1'b1;
            state        <= FRAMER_IDLE;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        default: state <= FRAMER_IDLE;
      endcase
    end
  end

  laser_word_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .pll_rst   (pll_rst),
    .flush     (flush),
    .push      (word_push),
    .push_data (push_word),
    .pop_req   (rd_en),
    .head_data (word_out),
    .not_empty (word_valid),
    .level     (fifo_level),
    .dropped   (fifo_dropped)
  );

  assign word_busy = word_valid && is_busy_word(word_out);

endmodule

// File: doc/laser_rx_word_framer.md
# laser_rx_word_framer

Assembles the byte stream delivered by the laser-link UART receiver (MBO_uart_rx, 186 clk/bit) into 32-bit big-endian response words. It buffers the words in a small first-word-fall-through (FWFT) FIFO and flags the laser's "busy / retry" status pattern on the head word. It sits directly downstream of the UART receiver and feeds the laser control sequencer, replacing ad-hoc byte shifting with a framed, timed-out, buffered word interface.

## Interface
- TIMEOUT_W, 25: width of the inter-byte timeout counter; timeout fires when bit TIMEOUT_W-1 sets (2^24 clk default).
- FIFO_AW, 2: FIFO address width; depth = 2^FIFO_AW words (4 default).

Ports:
- clk  in  1  system clock
- pll_rst  in  1  asynchronous, active-high reset
- rx_dv  in  1  one-cycle strobe: rx_byte valid
- rx_byte  in  8  received byte
- flush  in  1  discard partial word and all FIFO contents; clear overflow
- rd_en  in  1  pop head word (ignored when empty)
- word_out  out  32  head word; first byte received is in [31:24]
- word_valid  out  1  FIFO not empty
- word_busy  out  1  head is a busy word: word_out[23:16]==0 && word_out[3:0]!=0; forced 0 when !word_valid
- byte_timeout  out  1  one-cycle pulse: partial word dropped on timeout
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full
- fifo_level  out  FIFO_AW+1  number of stored words

## Operation
- Framer FSM:
  - IDLE: byte count 0, timeout counter held at 0. rx_dv stores the byte in [31:24], sets count=1 and moves to COLLECT.
  - COLLECT: timeout counter increments each cycle without rx_dv and clears to 0 on rx_dv. Each byte shifts in: shreg <= {shreg[23:0], rx_byte}.
  - On the 4th byte: push the assembled word; count returns to 0; return to IDLE.
  - Timeout counter MSB set while in COLLECT: drop the partial word, pulse byte_timeout, clear the counter, go to IDLE.
- FIFO: synchronous, FWFT. word_out and word_busy are valid whenever word_valid=1.
- Boundary rules:
  - rx_dv and timeout in the same cycle: the byte wins, the counter clears, and there is no timeout pulse.
  - Push when full without rd_en: word dropped, overflow<=1, level unchanged.
  - Push and rd_en in the same cycle when full: pop and push both complete, level stays 2^FIFO_AW, and overflow is not set.
  - Push and rd_en in the same cycle when empty: the word is stored (rd_en ignored), level becomes 1.
  - Push and rd_en in the same cycle otherwise: level unchanged.
  - rd_en while empty: no effect; pointers do not move.
  - flush has priority over all other inputs: FSM goes to IDLE, count and counter clear, pointers and level reset, overflow clears, and a coincident rx_dv byte is discarded.
  - Pointers wrap modulo 2^FIFO_AW. Level is computed with FIFO_AW+1 bits, so full = 2^FIFO_AW.
- Reset (pll_rst, async): FSM=IDLE, shreg=0, count=0, counter=0, pointers=0. All outputs are 0: word_out=0, word_valid=0, word_busy=0, byte_timeout=0, overflow=0, fifo_level=0. Reset mid-word discards the partial word; nothing is pushed.

## Timing
- 4th-byte rx_dv at cycle N: word_valid=1, word_out and fifo_level updated at N+1.
- rd_en at cycle N: the next head word (or word_valid=0) appears at N+1.
- Timeout: with the last rx_dv at cycle N, byte_timeout pulses at N + 2^(TIMEOUT_W-1) + 1. It is high for exactly one cycle.
- flush at N: all state cleared at N+1.
- rx_dv is honoured on back-to-back cycles, with no dead cycles between words.
- overflow rises at N+1 after the dropped push.

## Structure
- Shared package laser_link_pkg:
  - LASER_WORD_BYTES=4
  - framer state encoding (IDLE, COLLECT)
  - function is_busy_word(word) implementing the [23:16]==0 && [3:0]!=0 decode, also used by the control sequencer
  - UART bit-period constant 186
- One sub-module: laser_word_fifo (parameterised FWFT sync FIFO, FIFO_AW, 32-bit data, level output). The framer FSM and timeout counter live in the top.

## Test plan
- Bytes 0x12,0x34,0x56,0x78 with 3-cycle gaps -> word_out=0x12345678, word_valid=1 one cycle after the 4th byte, fifo_level=1, word_busy=0.
- Word 0x0A000003 -> word_busy=1. rd_en -> word_valid=0, word_busy=0, fifo_level=0.
- TIMEOUT_W=6: two bytes, then silence -> byte_timeout pulses once 33 cycles after the 2nd byte. A following 4-byte word assembles cleanly with no stale bytes.
- Six words with no rd_en (FIFO_AW=2) -> fifo_level=4, overflow=1, the first four words are intact. flush -> level=0, overflow=0.
- When full, the 4th byte arrives in the same cycle as rd_en -> level stays 4, overflow=0, and the new word appears at the tail.
- pll_rst asserted after the 2nd byte, then 4 new bytes -> only the new word is output and all outputs are 0 during reset.
